// File: rtl/class_router.sv
// class_router: drains a shared ingress FIFO (first-word fall-through) and
// steers each word into one of NUM_CLASSES per-class FIFOs, selected by the
// class field data_in[CLASS_MSB -: CLASS_WIDTH].
//
// Handshake: the ingress word is "valid" when empty=0. A word with a valid
// class is "ready" to move when almost_full[cls]=0. A word with an invalid
// class is always ready and is dropped. A transfer is one registered cycle in
// which pop is high together with exactly one of push[cls] or drop. Every
// transfer is followed by a one-cycle gap so the ingress head can advance.
//
// Optional feature macro: ROUTE_STATS_EN. When it is defined, the stall_count
// and routed_count saturating counters are built. When it is undefined, both
// ports are tied to zero. Routing behaviour is identical either way.
module class_router #(
  parameter int DATA_WIDTH  = 12,
  parameter int NUM_CLASSES = 4,
  parameter int CLASS_WIDTH = 2,
  parameter int CLASS_MSB   = DATA_WIDTH - 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic [3:0]             state,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   empty,
  input  logic [NUM_CLASSES-1:0] almost_full,
  output logic                   pop,
  output logic [NUM_CLASSES-1:0] push,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   drop,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   stall_count,
  output logic [CNT_WIDTH-1:0]   routed_count,
  output logic [1:0]             dbg_fsm_state
);

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_IDLE  = 2'd1,
    S_ISSUE = 2'd2
  } fsm_t;

  localparam logic [3:0] LS_RESET  = 4'b0001;
  localparam logic [3:0] LS_IDLE   = 4'b0100;
  localparam logic [3:0] LS_ACTIVE = 4'b1000;

  fsm_t                   r_fsm;
  fsm_t                   w_fsm_nxt;
  logic                   r_pop;
  logic [NUM_CLASSES-1:0] r_push;
  logic                   r_drop;
  logic [DATA_WIDTH-1:0]  r_data_out;

  logic                   w_enable;
  logic                   w_link_reset;
  logic [CLASS_WIDTH-1:0] w_cls;
  logic                   w_cls_valid;
  logic                   w_af_sel;
  logic                   w_req;
  logic                   w_fire;
  logic                   w_issue;

  // Only exact one-hot IDLE or ACTIVE enables routing; anything else is off.
  assign w_enable     = (state == LS_IDLE) || (state == LS_ACTIVE);
  assign w_link_reset = (state == LS_RESET);
  assign w_cls        = data_in[CLASS_MSB -: CLASS_WIDTH];
  assign w_cls_valid  = ({1'b0, w_cls} < (CLASS_WIDTH + 1)'(NUM_CLASSES));
  assign w_req        = w_enable && !empty;
  // Invalid classes bypass the almost-full check so they can never deadlock.
  assign w_fire       = w_req && (!w_cls_valid || !w_af_sel);
  assign w_issue      = (r_fsm == S_IDLE) && w_fire;

  // Select the almost-full flag of the head word's class; out-of-range reads 0.
  always_comb begin
    w_af_sel = 1'b0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (w_cls == CLASS_WIDTH'(i)) w_af_sel = almost_full[i];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) r_fsm <= S_RST;
    else          r_fsm <= w_fsm_nxt;
  end

  // FSM next state: link RESET overrides everything, ISSUE always lasts one cycle.
  always_comb begin
    w_fsm_nxt = r_fsm;
    if (w_link_reset) begin
      w_fsm_nxt = S_RST;
    end else begin
      case (r_fsm)
        S_RST:   w_fsm_nxt = S_IDLE;
        S_IDLE:  if (w_fire) w_fsm_nxt = S_ISSUE;
        S_ISSUE: w_fsm_nxt = S_IDLE;
        default: w_fsm_nxt = S_RST;
      endcase
    end
  end

  // Registered handshake outputs: pop with push or drop for the single ISSUE cycle.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_pop      <= 1'b0;
      r_push     <= '0;
      r_drop     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_pop  <= w_issue;
      r_push <= (w_issue && w_cls_valid) ? (NUM_CLASSES'(1) << w_cls) : '0;
      r_drop <= w_issue && !w_cls_valid;
      if (w_fsm_nxt == S_RST) r_data_out <= '0;
      else if (w_issue)       r_data_out <= data_in;
    end
  end

`ifdef ROUTE_STATS_EN
  logic [CNT_WIDTH-1:0] r_stall_count;
  logic [CNT_WIDTH-1:0] r_routed_count;
  logic                 w_blocked;

  assign w_blocked = (r_fsm == S_IDLE) && w_req && w_cls_valid && w_af_sel;

  // Saturating statistics counters, cleared whenever the FSM is in or enters RST.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_stall_count  <= '0;
      r_routed_count <= '0;
    end else if (w_fsm_nxt == S_RST) begin
      r_stall_count  <= '0;
      r_routed_count <= '0;
    end else begin
      if (w_blocked && (r_stall_count != '1))
        r_stall_count <= r_stall_count + CNT_WIDTH'(1);
      if (w_issue && w_cls_valid && (r_routed_count != '1))
        r_routed_count <= r_routed_count + CNT_WIDTH'(1);
    end
  end

  assign stall_count  = r_stall_count;
  assign routed_count = r_routed_count;
`else
  assign stall_count  = '0;
  assign routed_count = '0;
`endif

  assign pop           = r_pop;
  assign push          = r_push;
  assign drop          = r_drop;
  assign data_out      = r_data_out;
  assign busy          = (r_fsm == S_ISSUE);
  assign dbg_fsm_state = r_fsm;

endmodule

// File: tb/tb_class_router.sv
// Bench for class_router: FIFO-backed driver, behavioural reference model
// with a per-cycle compare process, ordered-delivery scoreboard and a few
// hand-computed directed expectations.
module tb_class_router;

  localparam int DW   = 12;
  localparam int NC   = 3;
  localparam int CW   = 2;
  localparam int CMSB = DW - 1;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            reset_L = 1'b0;
  logic [3:0]      state = 4'b0001;
  logic [DW-1:0]   data_in = '0;
  logic            empty = 1'b1;
  logic [NC-1:0]   almost_full = '0;
  logic            pop;
  logic [NC-1:0]   push;
  logic [DW-1:0]   data_out;
  logic            drop;
  logic            busy;
  logic [CNTW-1:0] stall_count;
  logic [CNTW-1:0] routed_count;
  logic [1:0]      dbg_fsm_state;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  // reference model state
  bit              m_rst = 1'b1;
  bit              m_pop = 1'b0;
  logic [NC-1:0]   m_push = '0;
  bit              m_drop = 1'b0;
  logic [DW-1:0]   m_data = '0;
  logic [CNTW-1:0] m_stall = '0;
  logic [CNTW-1:0] m_routed = '0;

  class_router #(
    .DATA_WIDTH(DW), .NUM_CLASSES(NC), .CLASS_WIDTH(CW),
    .CLASS_MSB(CMSB), .CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk), .reset_L(reset_L), .state(state), .data_in(data_in),
    .empty(empty), .almost_full(almost_full), .pop(pop), .push(push),
    .data_out(data_out), .drop(drop), .busy(busy),
    .stall_count(stall_count), .routed_count(routed_count),
    .dbg_fsm_state(dbg_fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [CNTW-1:0] exp_cnt(input logic [CNTW-1:0] v);
`ifdef ROUTE_STATS_EN
    return v;
`else
    return (v & '0);
`endif
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == '1) ? v : v + CNTW'(1);
  endfunction

  function automatic bit is_en(input logic [3:0] s);
    return (s == 4'b0100) || (s == 4'b1000);
  endfunction

  // driver helpers
  task automatic drive_head();
    if (fifo_q.size() > 0) begin
      data_in = fifo_q[0];
      empty   = 1'b0;
    end else begin
      data_in = DW'($urandom);
      empty   = 1'b1;
    end
  endtask

  task automatic load(input int cls);
    logic [DW-1:0] w;
    w = DW'($urandom);
    w[CMSB -: CW] = CW'(cls);
    fifo_q.push_back(w);
    if (cls < NC) exp_q.push_back(w);
    drive_head();
  endtask

  task automatic cycle();
    @(negedge clk);
    if (pop === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
    drive_head();
  endtask

  // reference model + compare: one registered transfer, then a gap; stalls only
  // for a valid class whose destination is almost full
  always @(posedge clk or negedge reset_L) begin
    logic [CW-1:0] c;
    if (!reset_L || state == 4'b0001) begin
      m_rst = 1'b1; m_pop = 1'b0; m_push = '0; m_drop = 1'b0;
      m_data = '0; m_stall = '0; m_routed = '0;
    end else if (m_rst) begin
      m_rst = 1'b0; m_pop = 1'b0; m_push = '0; m_drop = 1'b0;
    end else if (m_pop) begin
      m_pop = 1'b0; m_push = '0; m_drop = 1'b0;
    end else if (is_en(state) && !empty) begin
      c = data_in[CMSB -: CW];
      if (int'(c) >= NC) begin
        m_pop = 1'b1; m_drop = 1'b1; m_data = data_in;
      end else if (almost_full[c]) begin
        m_stall = sat_inc(m_stall);
      end else begin
        m_pop = 1'b1; m_push = NC'(1) << c; m_data = data_in;
        m_routed = sat_inc(m_routed);
      end
    end
    #1;
    chk("pop", pop, m_pop);
    chk("push", push, m_push);
    chk("drop", drop, m_drop);
    chk("busy", busy, m_pop);
    chk("data_out", data_out, m_data);
    chk("stall_count", stall_count, exp_cnt(m_stall));
    chk("routed_count", routed_count, exp_cnt(m_routed));
    if (reset_L && push !== '0 && clk) begin
      if (exp_q.size() == 0) chk("push_unexpected", push, 0);
      else chk("push_order", data_out, exp_q.pop_front());
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    // reset state
    chk("rst_pop", pop, 0);
    chk("rst_push", push, 0);
    chk("rst_drop", drop, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data_out, 0);
    // release with link RESET: holds in RST
    reset_L = 1'b1;
    repeat (3) cycle();
    chk("rst_hold_busy", busy, 0);

    // routing classes 0,1,2 at 2-cycle spacing
    state = 4'b1000;
    load(0); load(1); load(2);
    for (int i = 1; i <= 7; i++) begin
      cycle();
      if (i == 2) chk("route_c0", push, 3'b001);
      if (i == 3) chk("route_gap", pop, 0);
      if (i == 4) chk("route_c1", push, 3'b010);
      if (i == 6) chk("route_c2", push, 3'b100);
    end
    chk("route_cnt", routed_count, exp_cnt(3));

    // per-class stall
    almost_full = 3'b100;
    load(2);
    repeat (5) cycle();
    chk("stall_pop", pop, 0);
    chk("stall_cnt", stall_count, exp_cnt(5));
    almost_full = 3'b000;
    cycle();
    chk("stall_release", push, 3'b100);
    almost_full = 3'b100;
    load(1);
    cycle();
    cycle();
    chk("other_class", push, 3'b010);
    chk("stall_cnt_hold", stall_count, exp_cnt(5));
    cycle();

    // invalid class dropped despite almost_full
    almost_full = 3'b111;
    load(3);
    cycle();
    chk("inv_pop", pop, 1);
    chk("inv_drop", drop, 1);
    chk("inv_push", push, 0);
    chk("inv_routed", routed_count, exp_cnt(5));
    cycle();
    almost_full = 3'b000;

    // state gating during ISSUE
    load(0); load(1); load(2);
    cycle();
    chk("gate_issue", push, 3'b001);
    state = 4'b0010;
    cycle();
    chk("gate_complete", pop, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("gate_hold", pop, 0);
    end
    state = 4'b0100;
    cycle();
    chk("gate_resume", push, 3'b010);
    cycle();

    // link RESET clears outputs and counters
    state = 4'b0001;
    cycle();
    chk("sync_stall", stall_count, 0);
    chk("sync_routed", routed_count, 0);
    chk("sync_data", data_out, 0);

    // async reset in the middle of ISSUE
    state = 4'b1000;
    cycle();
    cycle();
    chk("async_pre", pop, 1);
    #2 reset_L = 1'b0;
    #1;
    chk("async_pop", pop, 0);
    chk("async_push", push, 0);
    chk("async_busy", busy, 0);
    chk("async_data", data_out, 0);
    @(negedge clk);
    reset_L = 1'b1;
    state = 4'b0001;
    repeat (3) cycle();
    chk("async_hold", busy, 0);

    // saturation
    state = 4'b1000;
    almost_full = 3'b001;
    load(0);
    repeat (20) cycle();
    chk("sat_stall", stall_count, exp_cnt(15));
    almost_full = 3'b000;
    repeat (3) cycle();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 9))
          0:       state = 4'b0001;
          1, 2:    state = 4'b0010;
          3, 4, 5: state = 4'b0100;
          6, 7, 8: state = 4'b1000;
          default: state = 4'($urandom);
        endcase
      end
      if ($urandom_range(0, 4) == 0) almost_full = NC'($urandom);
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 8) load($urandom_range(0, 3));
      cycle();
    end

    // drain
    state = 4'b1000;
    almost_full = '0;
    n = 0;
    while (fifo_q.size() > 0 && n < 200) begin
      cycle();
      n++;
    end
    repeat (3) cycle();
    chk("drain_fifo", fifo_q.size(), 0);
    chk("drain_scoreboard", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/class_router.md
# class_router

Parametrised transaction-layer class router. It drains one shared ingress FIFO and steers each word into one of NUM_CLASSES per-class FIFOs, using the class field carried in the word. Back-pressure is checked per destination, so only a word whose own class FIFO is almost full stalls. Words with an out-of-range class are dropped and flagged. The block sits between the ingress FIFO and the per-class FIFO bank, gated by the one-hot link-state vector.

## Interface
- DATA_WIDTH, 12: word width
- NUM_CLASSES, 4: destination FIFO count, 2..16
- CLASS_WIDTH, 2: class field width; must satisfy 2^CLASS_WIDTH >= NUM_CLASSES
- CLASS_MSB, DATA_WIDTH-1: MSB of the class field; the field is data_in[CLASS_MSB -: CLASS_WIDTH]
- CNT_WIDTH, 16: statistics counter width

Ports:
- clk  in  1  sole clock; all logic on its rising edge
- reset_L  in  1  asynchronous, active-low reset
- state  in  4  one-hot link state: 0001 RESET, 0010 INIT, 0100 IDLE, 1000 ACTIVE
- data_in  in  DATA_WIDTH  ingress FIFO head word, first-word fall-through
- empty  in  1  ingress FIFO empty
- almost_full  in  NUM_CLASSES  per-class FIFO almost-full flags
- pop  out  1  ingress FIFO pop
- push  out  NUM_CLASSES  per-class push, one-hot or zero
- data_out  out  DATA_WIDTH  word presented with push
- drop  out  1  one-cycle pulse when a word with an invalid class is popped
- busy  out  1  high while the FSM is in ISSUE
- stall_count  out  CNT_WIDTH  blocked-cycle count
- routed_count  out  CNT_WIDTH  pushed-word count

## Operation
- The enable condition is state==0100 or state==1000. Any other state value, including non-one-hot values, is treated as not enabled.
- cls = data_in[CLASS_MSB -: CLASS_WIDTH]. A class is valid when cls < NUM_CLASSES.
- FSM states: RST, IDLE, ISSUE.
  - RST is entered on reset_L=0 (asynchronous) or on state==0001 (synchronous). It leaves to IDLE on the first edge with reset_L=1 and state!=0001.
  - IDLE -> ISSUE when enable && !empty && (cls invalid || !almost_full[cls]). On this edge the block registers pop=1 and data_out=data_in. It also registers push[cls]=1 if the class is valid, or drop=1 if it is not.
  - ISSUE -> IDLE unconditionally. pop, push and drop clear on this edge. This one-cycle gap lets the ingress FIFO advance before the next class decode.
  - In IDLE with enable && !empty && cls valid && almost_full[cls], the block stays in IDLE with no pop. This is a blocked cycle.
- Words with an invalid class are always popped, regardless of almost_full, so they cannot deadlock the ingress FIFO.
- Counters saturate at all-ones and never wrap.
  - stall_count increments on every blocked cycle.
  - routed_count increments on every edge that registers a push.
  - Both counters clear only in RST.
- When state leaves the enable set while the FSM is in ISSUE, the ISSUE cycle completes normally, so the pop/push pair is never split. The FSM then holds in IDLE.
- An almost_full flag that changes during ISSUE has no effect on the word already issued.

## Timing
- Reset values: pop=0, push=0, data_out=0, drop=0, busy=0, counters=0, FSM=RST.
- All outputs are registered with no combinational input-to-output paths.
- Decision to pop/push is 1 cycle after data_in/empty are sampled in IDLE.
- Maximum throughput is one word every 2 cycles.
- pop, push and drop are each exactly one cycle wide. push and drop are never high together.
- pop is high in exactly the cycles where push or drop is high.
- data_out is stable during the push cycle and holds its value afterwards.
- The minimum pop-to-pop spacing is 2 cycles.

## Configuration
- Macro: ROUTE_STATS_EN.
  - Defined: stall_count and routed_count are implemented as specified.
  - Undefined: no counter registers exist and both ports are tied to 0. Routing behaviour is identical in both cases.

## Test plan
- Reset: assert reset_L=0 mid-ISSUE -> all outputs 0 immediately, without a clock edge. Release with state=0001 -> FSM holds in RST.
- Routing: state=1000, FIFO holds words with cls 0,1,2,3 and no almost_full -> push[0..3] fire in order at 2-cycle spacing, each with a matching pop; routed_count=4.
- Per-class stall: almost_full=0100, head cls=2 for 5 cycles -> no pop, stall_count=5. Clear almost_full -> push[2] one cycle later. With a head of cls=1 under almost_full=0100 -> routed immediately.
- Invalid class: NUM_CLASSES=3, head cls=3 with almost_full all set -> pop=1, drop=1, push=0 for one cycle; routed_count unchanged.
- State gating: switch state 1000->0010 during ISSUE -> the pop/push pair completes with no further pops. Return to 0100 -> resumes. Set state=0001 -> outputs and counters clear on the next edge.
- Saturation (ROUTE_STATS_EN, CNT_WIDTH=4): hold a blocked cycle 20 cycles -> stall_count=15. Without the macro -> both counter ports read 0.
